// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_B_DEF = 32'd8;
    localparam int unsigned FIFO_W_DEF = 32'd4;

    // Accepted-operation encoding: {write accepted, read accepted}
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned fifo_depth(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer strobe interface of the FIFO.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned B = FIFO_B_DEF
);
    logic         wr;
    logic [B-1:0] w_data;
    logic         rd;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;

    modport master (
        output wr, w_data, rd,
        input  r_data, empty, full
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, empty, full
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller: accept decisions, wrapping pointers, registered full/empty.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned W = FIFO_W_DEF
)
(
    input  logic         clk,
    input  logic         rstn_i,
    input  logic         wr_i,
    input  logic         rd_i,
    output logic [W-1:0] w_addr_o,
    output logic [W-1:0] r_addr_o,
    output logic         we_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam logic [W-1:0] PTR_ONE = W'(1'b1);

    logic [W-1:0] w_ptr_q, w_ptr_d;
    logic [W-1:0] r_ptr_q, r_ptr_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         wr_acc_s, rd_acc_s;
    logic [W-1:0] w_ptr_inc_s, r_ptr_inc_s;
    fifo_op_e     op_s;

    // A full FIFO still accepts a write when the same edge pops the head.
    assign wr_acc_s    = wr_i & (~full_q | rd_i);
    assign rd_acc_s    = rd_i & ~empty_q;
    assign op_s        = fifo_op_e'({wr_acc_s, rd_acc_s});
    assign w_ptr_inc_s = w_ptr_q + PTR_ONE;
    assign r_ptr_inc_s = r_ptr_q + PTR_ONE;

    // Next-state pointers and flags from the accepted operation
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        empty_d = empty_q;
        full_d  = full_q;
        case (op_s)
            OP_WR: begin
                w_ptr_d = w_ptr_inc_s;
                empty_d = 1'b0;
                full_d  = (w_ptr_inc_s == r_ptr_q);
            end
            OP_RD: begin
                r_ptr_d = r_ptr_inc_s;
                full_d  = 1'b0;
                empty_d = (r_ptr_inc_s == w_ptr_q);
            end
            OP_BOTH: begin
                w_ptr_d = w_ptr_inc_s;
                r_ptr_d = r_ptr_inc_s;
            end
            default: begin
                w_ptr_d = w_ptr_q;
                r_ptr_d = r_ptr_q;
            end
        endcase
    end

    // State registers with asynchronous reset to the empty condition
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign w_addr_o = w_ptr_q;
    assign r_addr_o = r_ptr_q;
    assign we_o     = wr_acc_s;
    assign empty_o  = empty_q;
    assign full_o   = full_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: storage array plus pointer controller.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned B = FIFO_B_DEF,
    parameter int unsigned W = FIFO_W_DEF
)
(
    input  logic        clk,
    input  logic        rstn_i,
    sync_fifo_if.slave  bus
);

    localparam int unsigned DEPTH = fifo_depth(W);

    logic [B-1:0] mem_q [DEPTH];
    logic [W-1:0] w_addr_s;
    logic [W-1:0] r_addr_s;
    logic         we_s;
    logic         empty_s;
    logic         full_s;

    fifo_ctrl #(
        .W (W)
    ) u_ctrl (
        .clk      (clk),
        .rstn_i   (rstn_i),
        .wr_i     (bus.wr),
        .rd_i     (bus.rd),
        .w_addr_o (w_addr_s),
        .r_addr_o (r_addr_s),
        .we_o     (we_s),
        .empty_o  (empty_s),
        .full_o   (full_s)
    );

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[w_addr_s] <= bus.w_data;
        end
    end

    assign bus.r_data = mem_q[r_addr_s];
    assign bus.empty  = empty_s;
    assign bus.full   = full_s;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: fill, drain, wrap, overlap, edge cases and async reset.
module tb_sync_fifo;

    logic clk;
    logic rstn_i;
    int   errors;
    int   checks;

    sync_fifo_if #(.B(8)) bus ();

    sync_fifo #(
        .B (8),
        .W (4)
    ) dut (
        .clk    (clk),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        bus.wr     = w;
        bus.rd     = r;
        bus.w_data = d;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rstn_i     = 1'b0;
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.w_data = 8'h00;

        // reset
        @(posedge clk);
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        rstn_i = 1'b1;

        // fill 01..10
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk("fill_empty", 32'(bus.empty),  32'd0);
            chk("fill_full",  32'(bus.full),   (i == 16) ? 32'd1 : 32'd0);
            chk("fill_head",  32'(bus.r_data), 32'h01);
        end
        step(1'b1, 1'b0, 8'hAA);
        chk("ovf_full", 32'(bus.full),   32'd1);
        chk("ovf_head", 32'(bus.r_data), 32'h01);

        // drain
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", 32'(bus.r_data), 32'(i));
            step(1'b0, 1'b1, 8'h00);
            chk("drain_empty", 32'(bus.empty), (i == 16) ? 32'd1 : 32'd0);
            chk("drain_full",  32'(bus.full),  32'd0);
        end
        step(1'b0, 1'b1, 8'h00);
        chk("udf_empty", 32'(bus.empty), 32'd1);
        chk("udf_full",  32'(bus.full),  32'd0);

        // wrap-around fill/drain 20..2F
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(32'h20 + i));
            chk("wfill_empty", 32'(bus.empty),  32'd0);
            chk("wfill_full",  32'(bus.full),   (i == 15) ? 32'd1 : 32'd0);
            chk("wfill_head",  32'(bus.r_data), 32'h20);
        end
        for (int i = 0; i < 16; i++) begin
            chk("wdrain_data", 32'(bus.r_data), 32'h20 + 32'(i));
            step(1'b0, 1'b1, 8'h00);
            chk("wdrain_empty", 32'(bus.empty), (i == 15) ? 32'd1 : 32'd0);
            chk("wdrain_full",  32'(bus.full),  32'd0);
        end

        // simultaneous read/write at occupancy 2
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        chk("sim_head0", 32'(bus.r_data), 32'h11);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b1, 8'(32'h30 + k));
            chk("sim_empty", 32'(bus.empty), 32'd0);
            chk("sim_full",  32'(bus.full),  32'd0);
            chk("sim_head",  32'(bus.r_data), (k == 0) ? 32'h22 : 32'h30 + 32'(k) - 32'd1);
        end
        step(1'b0, 1'b1, 8'h00);
        chk("sim_tail0", 32'(bus.r_data), 32'h3F);
        chk("sim_tail0_empty", 32'(bus.empty), 32'd0);
        step(1'b0, 1'b1, 8'h00);
        chk("sim_tail_empty", 32'(bus.empty), 32'd1);

        // empty with wr and rd together: write wins, read ignored
        step(1'b1, 1'b1, 8'h5A);
        chk("ewr_empty", 32'(bus.empty),  32'd0);
        chk("ewr_full",  32'(bus.full),   32'd0);
        chk("ewr_head",  32'(bus.r_data), 32'h5A);

        // full with wr and rd together: pop head, store in freed slot
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 8'(32'h60 + i));
        end
        chk("fwr_pre_full", 32'(bus.full), 32'd1);
        step(1'b1, 1'b1, 8'h77);
        chk("fwr_full",  32'(bus.full),   32'd1);
        chk("fwr_empty", 32'(bus.empty),  32'd0);
        chk("fwr_head",  32'(bus.r_data), 32'h60);
        for (int i = 0; i < 16; i++) begin
            chk("fwr_drain", 32'(bus.r_data), (i < 15) ? 32'h60 + 32'(i) : 32'h77);
            step(1'b0, 1'b1, 8'h00);
        end
        chk("fwr_drained", 32'(bus.empty), 32'd1);

        // asynchronous reset while full
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(32'h90 + i));
        end
        chk("arst_pre_full", 32'(bus.full), 32'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_full",  32'(bus.full),  32'd0);
        step(1'b1, 1'b0, 8'hEE);
        chk("arst_hold_empty", 32'(bus.empty), 32'd1);
        rstn_i = 1'b1;
        step(1'b1, 1'b0, 8'hC3);
        chk("post_rst_empty", 32'(bus.empty),  32'd0);
        chk("post_rst_head",  32'(bus.r_data), 32'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer with parameterised data width and power-of-two depth. It decouples a producer and a consumer in the same clock domain through a wr/rd strobe interface with full/empty flags. Read data is first-word-fall-through: the head entry is always presented on r_data, and rd pops it.

## Interface
- B, default 8: data width in bits.
- W, default 4: address width; depth is 2**W (16 by default).
- clk  input  1  clock; all state updates on the rising edge.
- rstn_i  input  1  asynchronous, active-low reset.
- wr  input  1  write strobe; pushes w_data at the rising edge when accepted.
- w_data  input  B  write data.
- rd  input  1  read strobe; pops the head entry at the rising edge when accepted.
- r_data  output  B  head entry, mem[r_ptr]; combinational from the storage array.
- empty  output  1  registered; 1 when occupancy = 0.
- full  output  1  registered; 1 when occupancy = 2**W.

## Operation
- Storage: 2**W x B register array. Write pointer w_ptr and read pointer r_ptr are each W bits and wrap modulo 2**W.
- Reset asserted (rstn_i = 0, asynchronous): w_ptr = 0, r_ptr = 0, empty = 1, full = 0. The array is not reset. r_data is undefined until the first write.
- Write accept: wr & (!full | rd).
  - Stores w_data at mem[w_ptr].
  - Increments w_ptr.
- Read accept: rd & !empty.
  - Increments r_ptr.
  - No read occurs when the FIFO is empty, even if wr is asserted in the same cycle.
- Flag update by accepted operation:
  - Write only: empty <= 0; full <= (w_ptr+1 == r_ptr).
  - Read only: full <= 0; empty <= (r_ptr+1 == w_ptr).
  - Both accepted: flags unchanged.
  - Neither accepted: no change.
- Rejected operations are silently dropped. There is no error flag.
  - Write when full without rd.
  - Read when empty.
- Empty with both wr and rd asserted: the write is performed and the read is ignored. Next cycle: empty = 0, r_data = written word.
- Full with both wr and rd asserted: head is popped and the new word is stored in the freed slot. full stays 1.
- Order is strictly preserved across pointer wrap-around.

## Timing
- Write-to-read latency is one edge. A word written at edge N appears on r_data after edge N, if it is the head. Empty falls after the same edge.
- r_data changes only after a clock edge. It follows r_ptr and the array with no added register stage.
- Flags are valid after each rising edge and after reset. Producer and consumer sample them combinationally before asserting strobes.
- Reset takes effect immediately, mid-operation included. The FIFO is considered empty. Deassertion is synchronous to the normal clock; the first write can occur on the first edge after release.

## Structure
- Shared package fifo_pkg: default B/W constants and a helper for the depth, 2**W.
- Sub-module fifo_ctrl: pointer registers, next-pointer logic and full/empty flag logic. It outputs w_addr, r_addr and we to the top level.
- The array is inferred in the top level. It is written at w_addr when we is asserted and read asynchronously at r_addr.

## Test plan
- Reset: assert rstn_i low for 1 cycle -> empty = 1, full = 0. Pointers at 0 checked by a first write landing at r_data.
- Fill: 16 writes of 8'h01..8'h10 -> empty = 0 after the first write; full = 1 after the 16th write. A 17th write (8'hAA) is ignored; content is unchanged.
- Drain: 16 reads -> r_data sequence 8'h01..8'h10 in order; empty = 1 after the 16th read. A 17th read leaves pointers and flags unchanged.
- Wrap-around: repeat fill/drain with new data 8'h20..8'h2F -> identical ordering and flag timing.
- Simultaneous: write 8'h11, 8'h22, then hold wr = rd = 1 for 16 cycles with incrementing data -> empty and full stay 0. r_data steps 8'h11, 8'h22, then the first word written during the overlap, and so on. Occupancy stays 2.
- Edge simultaneous and reset:
  - Empty, wr = rd = 1 with 8'h5A -> empty = 0, r_data = 8'h5A.
  - Full, wr = rd = 1 -> full stays 1 and head advances.
  - rstn_i low mid-stream -> empty = 1 and full = 0 immediately.
